// File: rtl/riscv_mem_pkg.sv
// Shared types, constants and the address check for the data-memory responder.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL     = 4'hF;

  // Misaligned word access or word index beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word storage with per-byte write enables and a combinational read.
module dmem_sram_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target: one request at a time, fixed wait states,
// registered response strobe and a stall back to the core.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic             cur_write;
  logic [31:0]      cur_addr;
  logic             cur_err;
  logic [IDX_W-1:0] arr_idx;
  logic             arr_we;
  logic [31:0]      arr_rdata;
  logic [31:0]      rdata_d;

  // In IDLE the live request is examined so a zero-wait response can be
  // formed at the accepting edge; afterwards only the captured copy matters.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
    end
    cur_err = addr_err(cur_addr, 32'(DEPTH_WORDS));
    arr_idx = cur_addr[IDX_W+1:2];
    arr_we  = (state_q == RESP) && write_q && !cur_err && !reset;
    rdata_d = (cur_err || cur_write) ? 32'h0000_0000 : arr_rdata;
  end

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .idx_i   (arr_idx),
    .we_i    (arr_we),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Request FSM with wait counter, capture registers and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            be_q       <= req_write ? req_be : BE_ALL;
            wait_cnt_q <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= cur_err;
            end else begin
              state_q <= WAIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= cur_err;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_stall = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Two responders (2 wait states / 1024 words, 0 wait states / 16 words) driven
// with directed requests and checked every cycle against a transaction model.
module tb_dmem_responder;

  localparam int NDUT = 2;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        reset     [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_write [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
  logic        mem_stall [NDUT];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_stall(mem_stall[0]));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_stall(mem_stall[1]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 1024 : 16;
  endfunction

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int resp_seen [NDUT];
  int stall_cnt [NDUT];

  // Transaction model: one outstanding request per responder.
  bit          pend    [NDUT];
  int          acc     [NDUT];
  bit          m_write [NDUT];
  logic [31:0] m_addr  [NDUT];
  logic [31:0] m_wdata [NDUT];
  logic [3:0]  m_be    [NDUT];
  bit          m_err   [NDUT];
  logic [31:0] m_rdata [NDUT];
  bit          m_known [NDUT];
  logic [31:0] mdl_mem [NDUT][1024];
  bit          known   [NDUT][1024];

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d cyc %0d: got %h, want %h", nm, d, cyc, act, exp);
    end
  endtask

  // Advance the model across the coming rising edge using this cycle's inputs.
  task automatic model_advance(input int d);
    int edge_n;
    int idx;
    edge_n = cyc + 1;
    if (reset[d]) begin
      pend[d] = 1'b0;
    end else if (pend[d]) begin
      if (edge_n == acc[d] + wait_of(d) + 1) begin
        if (m_write[d] && !m_err[d]) begin
          idx = int'(m_addr[d] / 32'd4);
          for (int b = 0; b < 4; b++)
            if (m_be[d][b]) mdl_mem[d][idx][8*b +: 8] = m_wdata[d][8*b +: 8];
          if (m_be[d] == 4'hF) known[d][idx] = 1'b1;
        end
        pend[d] = 1'b0;
      end
    end else if (req_valid[d]) begin
      pend[d]    = 1'b1;
      acc[d]     = edge_n;
      m_write[d] = req_write[d];
      m_addr[d]  = req_addr[d];
      m_wdata[d] = req_wdata[d];
      m_be[d]    = req_be[d];
      m_err[d]   = (req_addr[d] % 32'd4 != 32'd0) || (req_addr[d] / 32'd4 >= 32'(depth_of(d)));
      if (m_err[d] || m_write[d]) begin
        m_rdata[d] = 32'h0;
        m_known[d] = 1'b1;
      end else begin
        idx        = int'(req_addr[d] / 32'd4);
        m_rdata[d] = mdl_mem[d][idx];
        m_known[d] = known[d][idx];
      end
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  initial begin
    bit e_valid;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (cyc > 0) begin
          e_valid = pend[d] && (cyc == acc[d] + wait_of(d));
          check("req_ready", d, 32'(req_ready[d]), 32'(!pend[d]));
          check("rsp_valid", d, 32'(rsp_valid[d]), 32'(e_valid));
          check("rsp_err", d, 32'(rsp_err[d]), 32'(e_valid && m_err[d]));
          if (!e_valid || m_known[d])
            check("rsp_rdata", d, rsp_rdata[d], e_valid ? m_rdata[d] : 32'h0);
          check("mem_stall", d, 32'(mem_stall[d]),
                32'((!pend[d] && req_valid[d]) || (pend[d] && cyc < acc[d] + wait_of(d))));
          if (rsp_valid[d] === 1'b1) resp_seen[d]++;
          if (mem_stall[d] === 1'b1) stall_cnt[d]++;
        end
        model_advance(d);
      end
      cyc++;
    end
  end

  task automatic do_req(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er);
    int guard;
    int t0;
    int s0;
    rd = 32'h0;
    er = 1'b0;
    guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    s0 = stall_cnt[d];
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    t0 = cyc + 1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = 32'hFFFF_FFFC;
    req_wdata[d] = ~wd;
    req_be[d]    = 4'hF;
    guard = 0;
    while (rsp_valid[d] !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    if (guard >= 40) begin
      check("rsp_timeout", d, 32'd1, 32'd0);
    end else begin
      check("latency", d, 32'(cyc - t0), (d == 0) ? 32'd2 : 32'd0);
      check("stall_cycles", d, 32'(stall_cnt[d] - s0), (d == 0) ? 32'd3 : 32'd1);
      rd = rsp_rdata[d];
      er = rsp_err[d];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          r0;
    int          guard;
    for (int d = 0; d < NDUT; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_be[d] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) reset[d] = 1'b0;
    check("reset_ready", 0, 32'(req_ready[0]), 32'd1);
    check("reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);

    // Store then load.
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er);
    check("store_err", 0, 32'(er), 32'd0);
    check("store_rdata", 0, rd, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    check("load_rdata", 0, rd, 32'hDEAD_BEEF);
    check("load_err", 0, 32'(er), 32'd0);

    // Partial store: bytes 0 and 2 replaced.
    do_req(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er);
    do_req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    check("partial_rdata", 0, rd, 32'h11BB_33DD);

    // Zero byte enables leave the word alone.
    do_req(0, 1'b1, 32'h20, 32'h0000_0000, 4'b0000, rd, er);
    check("be0_err", 0, 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    check("be0_rdata", 0, rd, 32'h11BB_33DD);

    // Errors.
    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er);
    check("misalign_err", 0, 32'(er), 32'd1);
    check("misalign_rdata", 0, rd, 32'h0);
    do_req(0, 1'b1, 32'h0, 32'h0BAD_CAFE, 4'hF, rd, er);
    do_req(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("range_store_err", 0, 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
    check("range_store_nowrite", 0, rd, 32'h0BAD_CAFE);
    do_req(0, 1'b0, 32'h1010, 32'h0, 4'h0, rd, er);
    check("range_load_err", 0, 32'(er), 32'd1);
    check("range_load_rdata", 0, rd, 32'h0);

    // Reset during WAIT drops the store and its response.
    do_req(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, rd, er);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h40;
    req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("abort_in_wait", 0, 32'(mem_stall[0]), 32'd1);
    reset[0] = 1'b1;
    r0 = resp_seen[0];
    @(posedge clk); #1;
    reset[0] = 1'b0;
    check("abort_ready", 0, 32'(req_ready[0]), 32'd1);
    repeat (6) begin @(posedge clk); #1; end
    check("abort_no_rsp", 0, 32'(resp_seen[0] - r0), 32'd0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
    check("abort_old_value", 0, rd, 32'h1234_5678);

    // Zero wait states.
    do_req(1, 1'b1, 32'h4, 32'h1357_9BDF, 4'hF, rd, er);
    do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er);
    check("w0_load_rdata", 1, rd, 32'h1357_9BDF);
    do_req(1, 1'b1, 32'h40, 32'h5555_AAAA, 4'hF, rd, er);
    check("w0_range_err", 1, 32'(er), 32'd1);
    guard = 0;
    while (req_ready[1] !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h4; req_be[1] = 4'h0;
    for (int k = 0; k < 4; k++) begin
      check("ready_toggle", 1, 32'(req_ready[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
